// File: rtl/fetch_redirect_if.sv
// Purpose: fetch-redirect bundle between the fetch PC/tracking block and its
//          neighbours (hazard unit, BTB, EX-stage branch resolution).
// Signals:
//   stall_IF, stall_ID                  hazard-unit stalls
//   found_IF, pred_taken_IF             BTB hit / taken prediction for PC_IF
//   NPC_predicted_IF [31:0]             BTB next-PC
//   is_ctrl_EX, br_EX                   EX instruction is control / resolved taken
//   branch_target_EX [31:0]             resolved target
//   PC_IF, PC_EX [31:0]                 fetch PC, tracked EX PC
//   found_EX, pred_EX                   tracked EX prediction (0 on bubbles)
//   flush_ID, flush_EX, mispredict      redirect and younger-stage kill
// Modports: slave = fetch_redirect, master = its environment.
interface fetch_redirect_if;
   localparam int unsigned XLEN = 32;

   logic            stall_IF;
   logic            stall_ID;
   logic            found_IF;
   logic            pred_taken_IF;
   logic [XLEN-1:0] NPC_predicted_IF;
   logic            is_ctrl_EX;
   logic            br_EX;
   logic [XLEN-1:0] branch_target_EX;
   logic [XLEN-1:0] PC_IF;
   logic [XLEN-1:0] PC_EX;
   logic            found_EX;
   logic            pred_EX;
   logic            flush_ID;
   logic            flush_EX;
   logic            mispredict;

   modport master (
      output stall_IF, stall_ID, found_IF, pred_taken_IF, NPC_predicted_IF,
             is_ctrl_EX, br_EX, branch_target_EX,
      input  PC_IF, PC_EX, found_EX, pred_EX, flush_ID, flush_EX, mispredict
   );

   modport slave (
      input  stall_IF, stall_ID, found_IF, pred_taken_IF, NPC_predicted_IF,
             is_ctrl_EX, br_EX, branch_target_EX,
      output PC_IF, PC_EX, found_EX, pred_EX, flush_ID, flush_EX, mispredict
   );
endinterface

// File: rtl/fetch_redirect.sv
// Purpose: owns the fetch PC, applies the BTB next-PC prediction, tracks each
//          fetch's prediction through ID and EX, and redirects fetch / flushes
//          ID and EX when the EX-resolved outcome disagrees.
// Ports:
//   clk                  clock, rising edge
//   rst                  asynchronous active-low reset
//   fr (slave modport)   fetch_redirect_if bundle
//   ctrl_cnt, miss_cnt   [31:0] perf counters, only with FETCH_PERF_CNT_EN
// Configuration macro: FETCH_PERF_CNT_EN (adds ctrl_cnt / miss_cnt).
// mispredict / flush_* are combinational from EX registers and EX inputs.
module fetch_redirect #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   fetch_redirect_if.slave      fr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]          ctrl_cnt,
   output logic [31:0]          miss_cnt
`endif
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [0:0] {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_boot;

   logic [XLEN-1:0] r_pc_if;
   logic            r_valid_id, r_found_id, r_pred_id;
   logic [XLEN-1:0] r_pc_id, r_tgt_id;
   logic            r_valid_ex, r_found_ex, r_pred_ex;
   logic [XLEN-1:0] r_pc_ex, r_tgt_ex;

   logic            w_dir_miss;
   logic            w_tgt_miss;
   logic            w_mispredict;
   logic [XLEN-1:0] w_redirect_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic            w_fetch_valid;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_BOOT;
      else      r_state <= w_state_nxt;
   end

   // FSM next state: BOOT lasts exactly one cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_BOOT: w_state_nxt = ST_RUN;
         ST_RUN:  w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // FSM outputs
   always_comb begin
      w_boot = 1'b0;
      case (r_state)
         ST_BOOT: w_boot = 1'b1;
         default: w_boot = 1'b0;
      endcase
   end

   // Outcome vs. tracked prediction; a non-control op resolves not-taken
   always_comb begin
      w_dir_miss    = fr.br_EX != r_pred_ex;
      w_tgt_miss    = fr.br_EX & r_pred_ex & (fr.branch_target_EX != r_tgt_ex);
      w_mispredict  = r_valid_ex & (w_dir_miss | w_tgt_miss);
      w_redirect_pc = fr.br_EX ? fr.branch_target_EX : (r_pc_ex + XLEN'(4));
   end

   // Next fetch PC: redirect beats boot/stall hold, which beats the BTB
   always_comb begin
      w_pc_nxt      = r_pc_if;
      w_fetch_valid = ~w_boot & ~fr.stall_IF;
      if (w_mispredict)       w_pc_nxt = w_redirect_pc;
      else if (w_fetch_valid) w_pc_nxt = fr.NPC_predicted_IF;
   end

   // PC and IF->ID->EX tracking registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc_if    <= RESET_PC;
         r_valid_id <= 1'b0;
         r_found_id <= 1'b0;
         r_pred_id  <= 1'b0;
         r_pc_id    <= '0;
         r_tgt_id   <= '0;
         r_valid_ex <= 1'b0;
         r_found_ex <= 1'b0;
         r_pred_ex  <= 1'b0;
         r_pc_ex    <= '0;
         r_tgt_ex   <= '0;
      end else begin
         r_pc_if <= w_pc_nxt;
         if (w_mispredict) begin
            r_valid_id <= 1'b0;
            r_valid_ex <= 1'b0;
         end else if (fr.stall_ID) begin
            r_valid_ex <= 1'b0;
         end else begin
            r_valid_ex <= r_valid_id;
            r_found_ex <= r_found_id;
            r_pred_ex  <= r_pred_id;
            r_pc_ex    <= r_pc_id;
            r_tgt_ex   <= r_tgt_id;
            r_valid_id <= w_fetch_valid;
            r_found_id <= fr.found_IF;
            r_pred_id  <= fr.pred_taken_IF;
            r_pc_id    <= r_pc_if;
            r_tgt_id   <= fr.NPC_predicted_IF;
         end
      end
   end

   // Bubbles never present a hit/prediction to the BTB
   assign fr.PC_IF      = r_pc_if;
   assign fr.PC_EX      = r_pc_ex;
   assign fr.found_EX   = r_valid_ex & r_found_ex;
   assign fr.pred_EX    = r_valid_ex & r_pred_ex;
   assign fr.flush_ID   = w_mispredict;
   assign fr.flush_EX   = w_mispredict;
   assign fr.mispredict = w_mispredict;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_ctrl_cnt;
   logic [31:0] r_miss_cnt;

   // Control-op and mispredict counters, free-running modulo 2^32
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ctrl_cnt <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (r_valid_ex & fr.is_ctrl_EX) r_ctrl_cnt <= r_ctrl_cnt + 32'd1;
         if (w_mispredict)               r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign ctrl_cnt = r_ctrl_cnt;
   assign miss_cnt = r_miss_cnt;
`else
   logic w_unused_ctrl;
   assign w_unused_ctrl = fr.is_ctrl_EX;
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: directed vector table, directed redirect/stall/
// reset/wrap sequences, then randomized traffic against a reference model.
module tb_fetch_redirect;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_redirect_if bus_if ();
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] ctrl_cnt, miss_cnt;
`endif

   fetch_redirect #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .fr  (bus_if)
`ifdef FETCH_PERF_CNT_EN
      ,
      .ctrl_cnt (ctrl_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   // Reference model: one record per in-flight fetch in ID and EX
   typedef struct {
      bit          v;
      logic [31:0] pc;
      bit          f;
      bit          p;
      logic [31:0] tgt;
   } ent_t;

   ent_t        m_id, m_ex;
   bit          m_boot;
   logic [31:0] m_pc;
   int unsigned m_ctrl, m_miss;
   int          n_cmp = 0;
   int          n_err = 0;
   int          dut_mis = 0;

   bit          d_sif, d_sid, d_fnd, d_prd, d_ctl, d_br;
   logic [31:0] d_npc, d_tgt;

   // Directed BTB entry and resolution table for gen_cyc
   bit          btb_en;
   logic [31:0] btb_pc, btb_tgt;
   int          res_n;
   logic [31:0] res_pc [2];
   bit          res_br [2];
   logic [31:0] res_tgt [2];

   typedef struct {
      bit          sif, sid, fnd, prd;
      logic [31:0] npc;
      bit          ctl, br;
      logic [31:0] tgt;
      logic [31:0] e_pc;
      bit          e_mis, e_vex;
      logic [31:0] e_pcex;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_boot = 1'b1;
      m_pc   = 32'h0;
      m_id   = '{v: 1'b0, pc: 32'h0, f: 1'b0, p: 1'b0, tgt: 32'h0};
      m_ex   = '{v: 1'b0, pc: 32'h0, f: 1'b0, p: 1'b0, tgt: 32'h0};
      m_ctrl = 0;
      m_miss = 0;
   endtask

   task automatic drive(input bit sif, input bit sid, input bit fnd, input bit prd,
                        input logic [31:0] npc, input bit ctl, input bit br,
                        input logic [31:0] tgt);
      d_sif = sif; d_sid = sid; d_fnd = fnd; d_prd = prd;
      d_npc = npc; d_ctl = ctl; d_br = br; d_tgt = tgt;
      bus_if.stall_IF         = sif;
      bus_if.stall_ID         = sid;
      bus_if.found_IF         = fnd;
      bus_if.pred_taken_IF    = prd;
      bus_if.NPC_predicted_IF = npc;
      bus_if.is_ctrl_EX       = ctl;
      bus_if.br_EX            = br;
      bus_if.branch_target_EX = tgt;
      #1;
   endtask

   // Check the current cycle against the model, then advance one clock
   task automatic step();
      bit   mis;
      ent_t f;
      mis = m_ex.v && ((d_br != m_ex.p) || (d_br && m_ex.p && (d_tgt != m_ex.tgt)));
      chk ("pc_if",      bus_if.PC_IF,      m_pc);
      chk1("mispredict", bus_if.mispredict, mis);
      chk1("flush_id",   bus_if.flush_ID,   mis);
      chk1("flush_ex",   bus_if.flush_EX,   mis);
      chk1("found_ex",   bus_if.found_EX,   m_ex.v & m_ex.f);
      chk1("pred_ex",    bus_if.pred_EX,    m_ex.v & m_ex.p);
      if (m_ex.v) chk("pc_ex", bus_if.PC_EX, m_ex.pc);
      if (bus_if.mispredict === 1'b1) dut_mis++;
      if (m_ex.v && d_ctl) m_ctrl++;
      if (mis) m_miss++;
      f = '{v: !m_boot && !d_sif, pc: m_pc, f: d_fnd, p: d_prd, tgt: d_npc};
      if (mis) begin
         m_pc   = d_br ? d_tgt : m_ex.pc + 32'd4;
         m_id.v = 1'b0;
         m_ex.v = 1'b0;
      end else begin
         if (!m_boot && !d_sif) m_pc = d_npc;
         if (d_sid) m_ex.v = 1'b0;
         else begin
            m_ex = m_id;
            m_id = f;
         end
      end
      m_boot = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive from the directed BTB entry / resolution table
   task automatic gen_cyc(input bit sif, input bit sid, input bit do_step);
      bit          fnd, prd, ctl, br;
      logic [31:0] npc, tgt;
      fnd = 1'b0; prd = 1'b0; npc = m_pc + 32'd4;
      if (btb_en && m_pc == btb_pc) begin
         fnd = 1'b1; prd = 1'b1; npc = btb_tgt;
      end
      ctl = 1'b0; br = 1'b0; tgt = 32'h0;
      for (int i = 0; i < res_n; i++) begin
         if (m_ex.v && m_ex.pc == res_pc[i]) begin
            ctl = 1'b1; br = res_br[i]; tgt = res_tgt[i];
         end
      end
      drive(sif, sid, fnd, prd, npc, ctl, br, tgt);
      if (do_step) step();
   endtask

   // Asynchronous reset assertion, checked before any clock edge, then release
   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk ("rst_pc_if",      bus_if.PC_IF,      32'h0);
      chk1("rst_mispredict", bus_if.mispredict, 1'b0);
      chk1("rst_flush_id",   bus_if.flush_ID,   1'b0);
      chk1("rst_found_ex",   bus_if.found_EX,   1'b0);
      chk1("rst_pred_ex",    bus_if.pred_EX,    1'b0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_ctrl_cnt", ctrl_cnt, 32'h0);
      chk("rst_miss_cnt", miss_cnt, 32'h0);
`endif
      model_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      btb_en = 1'b0;
      res_n  = 0;
   endtask

   // Run directed cycles until the DUT shows 'want' more redirects (bounded)
   task automatic run_until_mis(input int want, input int bound, input string nm);
      int base;
      base = dut_mis;
      for (int k = 0; k < bound && (dut_mis - base) < want; k++) gen_cyc(1'b0, 1'b0, 1'b1);
      chk(nm, 32'(dut_mis - base), 32'(want));
   endtask

   initial begin
      int base;
      bit fnd, prd, sid, sif, ctl, br;
      logic [31:0] npc, tgt;

      //        sif sid fnd prd npc      ctl br tgt      e_pc     mis vex e_pcex
      tbl[0]  = '{0, 0, 0, 0, 32'h04, 0, 0, 32'h00, 32'h00, 0, 0, 32'h00};
      tbl[1]  = '{0, 0, 0, 0, 32'h04, 0, 0, 32'h00, 32'h00, 0, 0, 32'h00};
      tbl[2]  = '{0, 0, 0, 0, 32'h08, 0, 0, 32'h00, 32'h04, 0, 0, 32'h00};
      tbl[3]  = '{0, 0, 0, 0, 32'h0C, 0, 0, 32'h00, 32'h08, 0, 1, 32'h00};
      tbl[4]  = '{0, 0, 0, 0, 32'h10, 0, 0, 32'h00, 32'h0C, 0, 1, 32'h04};
      tbl[5]  = '{0, 0, 0, 0, 32'h14, 0, 0, 32'h00, 32'h10, 0, 1, 32'h08};
      tbl[6]  = '{0, 0, 0, 0, 32'h18, 0, 0, 32'h00, 32'h14, 0, 1, 32'h0C};
      tbl[7]  = '{0, 0, 0, 0, 32'h1C, 1, 1, 32'h40, 32'h18, 1, 1, 32'h10};
      tbl[8]  = '{0, 0, 0, 0, 32'h44, 0, 0, 32'h00, 32'h40, 0, 0, 32'h00};
      tbl[9]  = '{0, 0, 0, 0, 32'h48, 0, 0, 32'h00, 32'h44, 0, 0, 32'h00};
      tbl[10] = '{0, 0, 0, 0, 32'h4C, 0, 0, 32'h00, 32'h48, 0, 1, 32'h40};
      tbl[11] = '{0, 0, 0, 0, 32'h50, 0, 0, 32'h00, 32'h4C, 0, 1, 32'h44};

      #2;
      do_reset();

      // Boot hold, sequential fetch, unpredicted taken branch at 0x10
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].sif, tbl[i].sid, tbl[i].fnd, tbl[i].prd, tbl[i].npc,
               tbl[i].ctl, tbl[i].br, tbl[i].tgt);
         chk ($sformatf("tbl%0d_pc_if", i),      bus_if.PC_IF,      tbl[i].e_pc);
         chk1($sformatf("tbl%0d_mispredict", i), bus_if.mispredict, tbl[i].e_mis);
         chk1($sformatf("tbl%0d_flush_ex", i),   bus_if.flush_EX,   tbl[i].e_mis);
         chk1($sformatf("tbl%0d_pred_ex", i),    bus_if.pred_EX,    1'b0);
         if (tbl[i].e_vex) chk($sformatf("tbl%0d_pc_ex", i), bus_if.PC_EX, tbl[i].e_pcex);
         step();
      end

      // Predicted taken to 0x80 at 0x20, resolves not taken
      do_reset();
      btb_en = 1'b1; btb_pc = 32'h20; btb_tgt = 32'h80;
      res_n = 1; res_pc[0] = 32'h20; res_br[0] = 1'b0; res_tgt[0] = 32'h0;
      run_until_mis(1, 30, "nt_mis_count");
      chk("nt_redirect_pc", bus_if.PC_IF, 32'h24);

      // Predicted taken to 0x80, resolves taken to 0x90
      do_reset();
      btb_en = 1'b1; btb_pc = 32'h20; btb_tgt = 32'h80;
      res_n = 1; res_pc[0] = 32'h20; res_br[0] = 1'b1; res_tgt[0] = 32'h90;
      run_until_mis(1, 30, "tgt_mis_count");
      chk("tgt_redirect_pc", bus_if.PC_IF, 32'h90);

      // Predicted taken to 0x80, resolves taken to 0x80: zero penalty
      do_reset();
      btb_en = 1'b1; btb_pc = 32'h20; btb_tgt = 32'h80;
      res_n = 1; res_pc[0] = 32'h20; res_br[0] = 1'b1; res_tgt[0] = 32'h80;
      base = dut_mis;
      for (int k = 0; k < 15; k++) gen_cyc(1'b0, 1'b0, 1'b1);
      chk("hit_no_mis", 32'(dut_mis - base), 32'h0);
      chk("hit_pc_if", bus_if.PC_IF, 32'h94);

      // Mispredict on the first of three full-stall cycles, reset mid-stall
      do_reset();
      res_n = 1; res_pc[0] = 32'h10; res_br[0] = 1'b1; res_tgt[0] = 32'h40;
      for (int k = 0; k < 30 && !(m_ex.v && m_ex.pc == 32'h10); k++) gen_cyc(1'b0, 1'b0, 1'b1);
      gen_cyc(1'b1, 1'b1, 1'b1);
      chk("stall_redirect_pc", bus_if.PC_IF, 32'h40);
      gen_cyc(1'b1, 1'b1, 1'b1);
      chk("stall_hold_pc", bus_if.PC_IF, 32'h40);
      gen_cyc(1'b1, 1'b1, 1'b0);
      #2;
      do_reset();

      // Back-to-back: instruction at the redirect target mispredicts too
      res_n = 2;
      res_pc[0] = 32'h10; res_br[0] = 1'b1; res_tgt[0] = 32'h40;
      res_pc[1] = 32'h40; res_br[1] = 1'b1; res_tgt[1] = 32'h100;
      run_until_mis(2, 30, "b2b_mis_count");
      chk("b2b_redirect_pc", bus_if.PC_IF, 32'h100);
      for (int k = 0; k < 4; k++) gen_cyc(1'b0, 1'b0, 1'b1);

      // Not-taken correction at 0xFFFF_FFFC wraps to 0
      do_reset();
      btb_en = 1'b1; btb_pc = 32'hFFFF_FFFC; btb_tgt = 32'h200;
      res_n = 2;
      res_pc[0] = 32'h10;         res_br[0] = 1'b1; res_tgt[0] = 32'hFFFF_FFFC;
      res_pc[1] = 32'hFFFF_FFFC;  res_br[1] = 1'b0; res_tgt[1] = 32'h0;
      run_until_mis(2, 30, "wrap_mis_count");
      chk("wrap_redirect_pc", bus_if.PC_IF, 32'h0);

      // Randomized traffic against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         sid = ($urandom % 5) == 0;
         sif = sid & 1'($urandom);
         fnd = 1'($urandom);
         prd = fnd & 1'($urandom);
         npc = prd ? {$urandom, 2'b00} : m_pc + 32'd4;
         if (m_ex.v && ($urandom % 10) < 7) begin
            br  = m_ex.p;
            tgt = (br && ($urandom % 4) != 0) ? m_ex.tgt : {$urandom, 2'b00};
         end else begin
            br  = 1'($urandom);
            tgt = {$urandom, 2'b00};
         end
         ctl = br | 1'($urandom);
         drive(sif, sid, fnd, prd, npc, ctl, br, tgt);
         step();
      end
`ifdef FETCH_PERF_CNT_EN
      chk("ctrl_cnt", ctrl_cnt, 32'(m_ctrl));
      chk("miss_cnt", miss_cnt, 32'(m_miss));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_redirect.md
# fetch_redirect

- Owns the architectural fetch PC (`PC_IF`) and applies the BTB's next-PC prediction each cycle.
- Carries each fetch's prediction (taken bit, predicted target, BTB hit) down the IF→ID→EX tracking pipeline, alongside the fetched PC.
- Compares that prediction with the branch outcome resolved in EX. On a mismatch it redirects fetch and flushes the younger stages.
- Sits directly upstream of the BTB: it drives the BTB's `PC_IF` and its EX-side `found_EX`/`PC_EX`, and consumes `NPC_predicted_IF`.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset release.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall_IF`  in  1  hazard unit: hold PC and the IF→ID tracking register.
- `stall_ID`  in  1  hazard unit: hold the ID register; a bubble enters EX.
- `found_IF`  in  1  BTB hit for the current `PC_IF`.
- `pred_taken_IF`  in  1  BTB predicts taken.
- `NPC_predicted_IF`  in  32  BTB next PC.
- `is_ctrl_EX`  in  1  instruction in EX is a branch or jump.
- `br_EX`  in  1  resolved taken.
- `branch_target_EX`  in  32  resolved target.
- `PC_IF`  out  32  fetch address (registered).
- `PC_EX`, `found_EX`, `pred_EX`  out  32/1/1  tracked EX-stage values, sent to the BTB.
- `flush_ID`, `flush_EX`  out  1  kill the IF/ID and ID/EX pipeline registers at the next edge.
- `mispredict`  out  1  redirect this cycle.

## Operation
- Tracking registers: ID and EX stages each hold {valid, PC, found, pred, pred_target}. `pred_target` = `NPC_predicted_IF` captured at fetch.
- FSM:
  - BOOT: the single cycle after `rst` deasserts. `PC_IF`=`RESET_PC`, IF entry marked invalid, PC not advanced. Goes to RUN unconditionally.
  - RUN: the normal operating state. Remains in RUN.
- `mispredict` = valid_EX && (`br_EX` != pred_EX || (`br_EX` && pred_EX && `branch_target_EX` != pred_target_EX)).
  - A non-control instruction (`is_ctrl_EX`=0) has `br_EX`=0, so a stale taken prediction on it is also a mispredict.
- Correct target: `branch_target_EX` if `br_EX`, else `PC_EX`+4.
- Next-PC priority at each edge:
  - mispredict → correct target;
  - else BOOT or `stall_IF` → hold;
  - else `NPC_predicted_IF` (equals `PC_IF`+4 when not predicted taken).
- `flush_ID` = `flush_EX` = `mispredict`. On mispredict, valid_ID and valid_EX clear at the edge, overriding both stalls.
- `stall_ID` holds the ID entry and writes valid_EX=0. `stall_IF` without `stall_ID` is invalid; hazard unit guarantees this.
- All additions are 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Outputs `found_EX`/`pred_EX` are forced 0 whenever valid_EX=0, so the BTB never trains on bubbles.

## Timing
- `rst` low (asynchronous):
  - FSM=BOOT, `PC_IF`=`RESET_PC`, all valid/found/pred bits 0, targets and `PC_EX` 0.
  - `flush_ID`, `flush_EX` and `mispredict` are 0.
- Reset asserted mid-operation clears all state immediately; no pending redirect survives.
- `mispredict` and `flush_*` are combinational from EX registers and EX inputs, valid in the same cycle.
- Redirected `PC_IF` appears one edge after `mispredict`. Penalty is 2 bubbles (ID and EX).
- Correct prediction has zero penalty: `PC_IF` follows `NPC_predicted_IF` every unstalled edge.
- Back-to-back: the instruction fetched at the redirect target is valid. It can itself mispredict 2 cycles later.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `ctrl_cnt` [31:0] and `miss_cnt` [31:0].
  - `ctrl_cnt` increments each cycle with valid_EX && `is_ctrl_EX`.
  - `miss_cnt` increments each cycle `mispredict` is 1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset release, no stalls, BTB misses → `PC_IF` = 0,0,4,8,… (BOOT holds one cycle); `mispredict` never 1.
- Branch at 0x10, `pred_taken_IF`=0, resolves `br_EX`=1 target 0x40 → `mispredict`=`flush_ID`=`flush_EX`=1 for one cycle; next `PC_IF`=0x40; `found_EX`/`pred_EX` 0 on following bubbles.
- Predicted taken to 0x80 at PC 0x20, resolves not taken → next `PC_IF`=0x24.
- Predicted taken to 0x80, resolves taken to 0x90 → redirect to 0x90; same target 0x80 → no flush, zero bubbles.
- `stall_IF`=`stall_ID`=1 for 3 cycles while EX mispredicts on the first stall cycle → redirect wins, `PC_IF` takes the target, valid_ID/valid_EX clear; drop `rst` mid-stall → `PC_IF`=`RESET_PC` asynchronously.
- With `FETCH_PERF_CNT_EN`, 10 branches with 3 mispredicts → `ctrl_cnt`=10, `miss_cnt`=3.
